// File: rtl/div_pkg.sv
// Shared types and operand helpers for the multi-cycle MIPS DIV/DIVU unit.
package div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    function automatic logic [DIV_W-1:0] op_mag(input logic [DIV_W-1:0] v, input logic is_signed);
        return (is_signed && v[DIV_W-1]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock; result is {remainder, quotient}.
// Raises stallreq_o while a requested division is still in flight.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [63:0] work_q;
    logic [63:0] work_d;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        sign1_q;
    logic        sign2_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [32:0] minuend;
    logic [33:0] trial;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // The bit shifted out of the top is kept in the minuend: with a divisor
    // above 2^31 the partial remainder can occupy all 32 upper bits.
    always_comb begin
        minuend = {work_q[63], work_q[62:31]};
        trial   = {1'b0, minuend} - {2'b00, divisor_q};
        if (!trial[33]) begin
            work_d = {trial[31:0], work_q[30:0], 1'b1};
        end else begin
            work_d = {work_q[62:0], 1'b0};
        end
        quo_fix = cond_neg(work_d[31:0],  signed_q & (sign1_q ^ sign2_q));
        rem_fix = cond_neg(work_d[63:32], signed_q & sign1_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= 5'd0;
            work_q    <= 64'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= 64'd0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                DIV_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= DIV_BYZERO;
                        end else begin
                            state_q   <= DIV_ON;
                            cnt_q     <= 5'd0;
                            work_q    <= {32'd0, op_mag(opdata1_i, signed_div_i)};
                            divisor_q <= op_mag(opdata2_i, signed_div_i);
                            signed_q  <= signed_div_i;
                            sign1_q   <= opdata1_i[31];
                            sign2_q   <= opdata2_i[31];
                        end
                    end
                end
                DIV_BYZERO: begin
                    state_q  <= DIV_END;
                    result_q <= 64'd0;
                    ready_q  <= 1'b1;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state_q <= DIV_FREE;
                        cnt_q   <= 5'd0;
                        work_q  <= 64'd0;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= DIV_END;
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                DIV_END: begin
                    // EX holds start_i until it has taken the result.
                    if (annul_i || !start_i) begin
                        state_q  <= DIV_FREE;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: state_q <= DIV_FREE;
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div.sv
// Directed checks of the multi-cycle divider: latency, stall handshake, signs, abort, reset.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int checks = 0;
    int errors = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns with start_i still high, #1 after the edge that raised ready_o.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int stalls);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        edges  = 0;
        stalls = 0;
        #1;
        while (edges < 40) begin
            if (stallreq_o) stalls++;
            @(posedge clk);
            #1;
            edges++;
            if (ready_o) break;
        end
    endtask

    // Holds start_i for extra cycles in END, then drops it and expects a clean return to FREE.
    task automatic finish_op(input string tag, input int hold, input logic [63:0] exp);
        check({tag, "_stall_at_ready"}, {63'd0, stallreq_o}, 64'd0);
        check({tag, "_result"}, result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            check({tag, "_hold_result"}, result_o, exp);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int edges;
        int stalls;
        int hits;

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #3;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // DIVU 100 / 7
        run_op(1'b0, 32'd100, 32'd7, edges, stalls);
        check("divu_latency", edges, 64'd33);
        check("divu_stall_cycles", stalls, 64'd33);
        finish_op("divu_100_7", 0, {32'd2, 32'd14});

        // DIV -7 / 2
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, edges, stalls);
        check("div_m7_2_latency", edges, 64'd33);
        finish_op("div_m7_2", 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // DIV 7 / -2
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, edges, stalls);
        finish_op("div_7_m2", 0, {32'd1, 32'hFFFF_FFFD});

        // DIV -7 / -2
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, edges, stalls);
        finish_op("div_m7_m2", 0, {32'hFFFF_FFFF, 32'd3});

        // DIV 0x80000000 / -1: no trap, quotient wraps
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, stalls);
        finish_op("div_min_m1", 0, {32'd0, 32'h8000_0000});

        // DIVU with divisor above 2^31
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, edges, stalls);
        finish_op("divu_big_divisor", 0, {32'h7FFF_FFFE, 32'd1});

        // Divide by zero
        run_op(1'b0, 32'd5, 32'd0, edges, stalls);
        check("byzero_latency", edges, 64'd2);
        finish_op("byzero", 0, 64'd0);

        // Annul at iteration 10, start dropped with it
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_stall_comb", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) hits++;
        end
        check("annul_never_ready", hits, 64'd0);
        @(negedge clk);

        // DIVU after the abort, with a held result
        run_op(1'b0, 32'hFFFF_FFFF, 32'h10, edges, stalls);
        check("restart_latency", edges, 64'd33);
        finish_op("divu_ffff_10", 3, {32'hF, 32'h0FFF_FFFF});

        // start together with annul in FREE is ignored; next request gets full latency
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1;
        opdata2_i    = 32'd1;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ignored_ready", {63'd0, ready_o}, 64'd0);
        check("ignored_stall", {63'd0, stallreq_o}, 64'd0);
        run_op(1'b0, 32'd50, 32'd5, edges, stalls);
        check("ignored_then_latency", edges, 64'd33);
        finish_op("divu_50_5", 0, {32'd0, 32'd10});

        // Asynchronous reset at iteration 20, between edges
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (21) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        check("midrst_stall", {63'd0, stallreq_o}, 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'd100, 32'd7, edges, stalls);
        check("after_rst_latency", edges, 64'd33);
        finish_op("after_rst_100_7", 0, {32'd2, 32'd14});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
